// File: rtl/comm_ic_pkg.sv
// Shared definitions for the comm IC SPI blocks (master and target).
package comm_ic_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_tgt_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer with rise/fall pulses taken from the last two synchronized samples.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first: oversampled pins, received words as strobes,
// transmit words from a single-entry valid/ready buffer.
//
// state  | meaning
// IDLE   | SEN deasserted, MISO tri-stated, SCLK ignored
// ACTIVE | SEN asserted, shifting on synchronized SCLK edges
module spi_target
    import comm_ic_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              SEN,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sen_sync, sen_rise, sen_fall;
    logic unused_sclk_level, sclk_rise, sclk_fall;
    logic mosi_sync;
    logic [SYNC_STAGES-1:0] mosi_chain;

    spi_tgt_state_e    state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
    logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
    logic [DATA_W-1:0] rx_data_nxt;
    logic              rx_valid_nxt, underrun_nxt;
    logic [DATA_W-1:0] buf_data, buf_data_nxt;
    logic              buf_full, buf_full_nxt;
    logic              consume, write;

    // SEN idles high so reset must not manufacture a select edge.
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sen_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (SEN),
        .sync    (sen_sync),
        .rise    (sen_rise),
        .fall    (sen_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (SCLK),
        .sync    (unused_sclk_level),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mosi_chain <= '0;
        else          mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
    end

    assign mosi_sync = mosi_chain[SYNC_STAGES-1];
    assign write     = tx_valid && !buf_full;

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        underrun_nxt = 1'b0;
        consume      = 1'b0;

        case (state)
            IDLE: begin
                if (sen_fall) begin
                    state_nxt   = ACTIVE;
                    bit_cnt_nxt = '0;
                    consume     = 1'b1;
                end
            end
            ACTIVE: begin
                if (sen_rise) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end else if (!sen_sync) begin
                    if (sclk_rise) begin
                        rx_shift_nxt = {rx_shift[DATA_W-2:0], mosi_sync};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_nxt  = '0;
                            rx_data_nxt  = {rx_shift[DATA_W-2:0], mosi_sync};
                            rx_valid_nxt = 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                    // A falling edge at bit 0 closes a word: load the next one for bursts.
                    if (sclk_fall) begin
                        if (bit_cnt == '0) consume = 1'b1;
                        else               tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A consume sees the buffer as it was before any same-cycle write.
        if (consume) begin
            tx_shift_nxt = buf_full ? buf_data : IDLE_BYTE;
            underrun_nxt = !buf_full;
        end

        buf_full_nxt = (buf_full && !consume) || write;
        buf_data_nxt = write ? tx_data : buf_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            buf_data <= '0;
            buf_full <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx_shift <= tx_shift_nxt;
            rx_shift <= rx_shift_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            underrun <= underrun_nxt;
            buf_data <= buf_data_nxt;
            buf_full <= buf_full_nxt;
        end
    end

    assign busy     = (state == ACTIVE);
    assign MISO_oe  = (state == ACTIVE);
    assign MISO     = (state == ACTIVE) && tx_shift[DATA_W-1];
    assign tx_ready = !buf_full;

endmodule
